// File: rtl/bus_timer_if.sv
// bus_timer_if -- CPU-side register bus between the 6502 page decode and the
// bus_timer responder.
//
// Signals:
//   cs    chip select from the page decode
//   we    write enable (1 = write)
//   rs    register select, CPU_AB[1:0]
//   din   CPU write data
//   dout  registered read data from the timer
//   irq   level interrupt request from the timer
//
// Modports:
//   master  the CPU / decode side; drives cs, we, rs, din
//   slave   the timer side; drives dout, irq
interface bus_timer_if;
    logic       cs;
    logic       we;
    logic [1:0] rs;
    logic [7:0] din;
    logic [7:0] dout;
    logic       irq;

    modport master (
        output cs,
        output we,
        output rs,
        output din,
        input  dout,
        input  irq
    );

    modport slave (
        input  cs,
        input  we,
        input  rs,
        input  din,
        output dout,
        output irq
    );
endinterface

// File: rtl/bus_timer.sv
// bus_timer -- memory-mapped 16-bit interval timer on the 6502 CPU bus.
//
// A prescaler divides clk into ticks and a 16-bit down-counter decrements on
// each tick. When a tick finds the counter at zero the zero flag is set; in
// auto-reload mode the counter is refilled from the latch, in one-shot mode
// the timer disables itself. irq is the level zf & ie.
//
// Register map (rs):
//   0  W: latch[7:0]               R: count[7:0] (also snapshots count[15:8])
//   1  W: latch[15:8] and load     R: snapshotted high byte
//   2  W: CTRL {ie, cont, en}      R: {5'b0, ie, cont, en}
//   3  W: bit7 = 1 clears zf       R: {zf, 6'b0, en}
//
// Ports:
//   clk    system / CPU clock
//   reset  synchronous, active-high reset
//   bus    slave side of bus_timer_if (cs, we, rs, din, dout, irq)
//
// Parameters:
//   PRESCALE  clk cycles per counter tick (>= 1)
module bus_timer #(
    parameter int PRESCALE = 16
) (
    input  logic        clk,
    input  logic        reset,
    bus_timer_if.slave  bus
);

    // Prescaler width is kept at least one bit so PRESCALE = 1 still elaborates;
    // in that case the prescaler simply sits at 0 and every enabled cycle ticks.
    localparam int            PW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_MAX = PW'(PRESCALE - 1);

    logic [15:0]   latch;
    logic [15:0]   count;
    logic [7:0]    hi_snap;
    logic          en;
    logic          cont;
    logic          ie;
    logic          zf;
    logic [PW-1:0] prescaler;
    logic [7:0]    dout_q;

    logic          wr_lo;
    logic          wr_load;
    logic          wr_ctrl;
    logic          wr_clr;
    logic          rd_lo;
    logic          tick;
    logic          tick_eff;
    logic          underflow;
    logic [7:0]    rdata;

    // Bus decode. Nothing happens without cs, including the read side effect.
    always_comb begin
        wr_lo   = 1'b0;
        wr_load = 1'b0;
        wr_ctrl = 1'b0;
        wr_clr  = 1'b0;
        rd_lo   = 1'b0;
        if (bus.cs) begin
            if (bus.we) begin
                unique case (bus.rs)
                    2'd0: wr_lo   = 1'b1;
                    2'd1: wr_load = 1'b1;
                    2'd2: wr_ctrl = 1'b1;
                    2'd3: wr_clr  = bus.din[7];
                endcase
            end else begin
                rd_lo = (bus.rs == 2'd0);
            end
        end
    end

    // A tick is swallowed by a load write (the load wins) and by a CTRL write
    // that turns the timer off in the same cycle.
    always_comb begin
        tick      = en && (prescaler == PS_MAX);
        tick_eff  = tick && !wr_load && !(wr_ctrl && !bus.din[0]);
        underflow = tick_eff && (count == 16'd0);
    end

    // Read mux; sampled into dout every cycle regardless of cs.
    always_comb begin
        rdata = 8'h00;
        unique case (bus.rs)
            2'd0: rdata = count[7:0];
            2'd1: rdata = hi_snap;
            2'd2: rdata = {5'b0, ie, cont, en};
            2'd3: rdata = {zf, 6'b0, en};
        endcase
    end

    // Prescaler: held at 0 while disabled, restarted by a load write so the
    // first decrement after a load is a full PRESCALE period away.
    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler <= '0;
        end else if (wr_load || !en) begin
            prescaler <= '0;
        end else if (prescaler == PS_MAX) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PW'(1);
        end
    end

    // Latch and down-counter. Writing the low latch byte never touches count;
    // it only takes effect on the next load write or auto-reload.
    always_ff @(posedge clk) begin
        if (reset) begin
            latch <= 16'h0000;
            count <= 16'h0000;
        end else begin
            if (wr_lo) begin
                latch[7:0] <= bus.din;
            end
            if (wr_load) begin
                latch[15:8] <= bus.din;
                count       <= {bus.din, latch[7:0]};
            end else if (tick_eff) begin
                if (count != 16'd0) begin
                    count <= count - 16'd1;
                end else if (cont) begin
                    count <= latch;
                end
            end
        end
    end

    // Control bits. A CTRL write beats the one-shot auto-disable.
    always_ff @(posedge clk) begin
        if (reset) begin
            en   <= 1'b0;
            cont <= 1'b0;
            ie   <= 1'b0;
        end else if (wr_ctrl) begin
            en   <= bus.din[0];
            cont <= bus.din[1];
            ie   <= bus.din[2];
        end else if (underflow && !cont) begin
            en <= 1'b0;
        end
    end

    // Zero flag: a set from underflow beats a simultaneous clear write.
    always_ff @(posedge clk) begin
        if (reset) begin
            zf <= 1'b0;
        end else if (underflow) begin
            zf <= 1'b1;
        end else if (wr_clr) begin
            zf <= 1'b0;
        end
    end

    // Reading the low byte freezes the high byte so lo-then-hi is coherent.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_snap <= 8'h00;
            dout_q  <= 8'h00;
        end else begin
            if (rd_lo) begin
                hi_snap <= count[15:8];
            end
            dout_q <= rdata;
        end
    end

    assign bus.dout = dout_q;
    assign bus.irq  = zf & ie;

endmodule

// File: tb/tb_bus_timer.sv
// tb_bus_timer -- directed self-checking bench for bus_timer.
//
// Two instances: dut0 with PRESCALE = 4 for most scenarios and dut1 with
// PRESCALE = 1 for the coherent lo/hi read. Inputs change 1 time unit after
// the rising edge; outputs are sampled at the same point.
module tb_bus_timer;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    bus_timer_if bus0 ();
    bus_timer_if bus1 ();

    bus_timer #(.PRESCALE(4)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    bus_timer #(.PRESCALE(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        bus0.cs  = 1'b1;
        bus0.we  = 1'b1;
        bus0.rs  = a;
        bus0.din = d;
        @(posedge clk);
        #1;
        bus0.cs = 1'b0;
        bus0.we = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        bus0.cs = 1'b1;
        bus0.we = 1'b0;
        bus0.rs = a;
        @(posedge clk);
        #1;
        d       = bus0.dout;
        bus0.cs = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        bus_write(2'd0, 8'h05);
        bus_write(2'd1, 8'h00);
        bus_write(2'd2, 8'h07);
        idle_cycles(6);
        reset = 1'b1;
        idle_cycles(2);
        reset = 1'b0;
        total++;
        if (bus0.dout !== 8'h00) begin
            bad++;
            $display("[TB] FAIL reset_dout: got %h expected 00", bus0.dout);
        end
        total++;
        if (bus0.irq !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_irq: got %b expected 0", bus0.irq);
        end
        bus_read(2'd2, d);
        total++;
        if (d !== 8'h00) begin
            bad++;
            $display("[TB] FAIL reset_ctrl: got %h expected 00", d);
        end
        bus_read(2'd3, d);
        total++;
        if (d !== 8'h00) begin
            bad++;
            $display("[TB] FAIL reset_status: got %h expected 00", d);
        end
        bus_read(2'd0, d);
        total++;
        if (d !== 8'h00) begin
            bad++;
            $display("[TB] FAIL reset_count: got %h expected 00", d);
        end
    endtask

    // Count 3, PRESCALE 4: ticks at +4, +8, +12 reach 0, +16 underflows.
    task automatic test_one_shot();
        logic [7:0] d;
        bus_write(2'd0, 8'h03);
        bus_write(2'd1, 8'h00);
        bus_write(2'd2, 8'h05);
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk);
            #1;
            if (i == 15) begin
                total++;
                if (bus0.irq !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL oneshot_early_irq: got %b expected 0", bus0.irq);
                end
            end
            if (i == 16) begin
                total++;
                if (bus0.irq !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL oneshot_irq_at_16: got %b expected 1", bus0.irq);
                end
            end
        end
        bus_read(2'd3, d);
        total++;
        if (d !== 8'h80) begin
            bad++;
            $display("[TB] FAIL oneshot_status: got %h expected 80", d);
        end
        idle_cycles(8);
        bus_read(2'd0, d);
        total++;
        if (d !== 8'h00) begin
            bad++;
            $display("[TB] FAIL oneshot_count_hold: got %h expected 00", d);
        end
    endtask

    // Runs with zf=1, ie=1, en=0, latch=0x0003 left by the one-shot scenario.
    task automatic test_chip_select();
        logic [7:0] d;
        logic [7:0] vals [4];
        vals = '{8'hAA, 8'hBB, 8'h07, 8'h80};
        for (int k = 0; k < 4; k++) begin
            bus0.cs  = 1'b0;
            bus0.we  = 1'b1;
            bus0.rs  = 2'(k);
            bus0.din = vals[k];
            @(posedge clk);
            #1;
        end
        bus0.we = 1'b0;
        bus_read(2'd3, d);
        total++;
        if (d !== 8'h80) begin
            bad++;
            $display("[TB] FAIL cs_status: got %h expected 80", d);
        end
        bus_read(2'd2, d);
        total++;
        if (d !== 8'h04) begin
            bad++;
            $display("[TB] FAIL cs_ctrl: got %h expected 04", d);
        end
        total++;
        if (bus0.irq !== 1'b1) begin
            bad++;
            $display("[TB] FAIL cs_irq: got %b expected 1", bus0.irq);
        end
        bus_read(2'd0, d);
        total++;
        if (d !== 8'h00) begin
            bad++;
            $display("[TB] FAIL cs_count: got %h expected 00", d);
        end
        bus_write(2'd1, 8'h00);
        bus_read(2'd0, d);
        total++;
        if (d !== 8'h03) begin
            bad++;
            $display("[TB] FAIL cs_latch_lo: got %h expected 03", d);
        end
        bus_write(2'd3, 8'h80);
        total++;
        if (bus0.irq !== 1'b0) begin
            bad++;
            $display("[TB] FAIL cs_zf_clear: got %b expected 0", bus0.irq);
        end
    endtask

    // Latch 2, PRESCALE 4: underflow every 12 clocks. Ends with a clear write
    // landing on the third set edge.
    task automatic test_auto_reload();
        logic [7:0] d;
        bus_write(2'd0, 8'h02);
        bus_write(2'd1, 8'h00);
        bus_write(2'd2, 8'h07);
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            if (i == 11) begin
                total++;
                if (bus0.irq !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL reload_early_irq: got %b expected 0", bus0.irq);
                end
            end
            if (i == 12) begin
                total++;
                if (bus0.irq !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL reload_irq_at_12: got %b expected 1", bus0.irq);
                end
            end
        end
        bus_write(2'd3, 8'h80);
        total++;
        if (bus0.irq !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reload_clear: got %b expected 0", bus0.irq);
        end
        for (int i = 1; i <= 11; i++) begin
            @(posedge clk);
            #1;
            if (i == 10) begin
                total++;
                if (bus0.irq !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL reload_second_early: got %b expected 0", bus0.irq);
                end
            end
            if (i == 11) begin
                total++;
                if (bus0.irq !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL reload_irq_at_24: got %b expected 1", bus0.irq);
                end
            end
        end
        idle_cycles(11);
        bus_write(2'd3, 8'h80);
        total++;
        if (bus0.irq !== 1'b1) begin
            bad++;
            $display("[TB] FAIL collide_set_vs_clear_irq: got %b expected 1", bus0.irq);
        end
        bus_read(2'd3, d);
        total++;
        if (d !== 8'h81) begin
            bad++;
            $display("[TB] FAIL collide_set_vs_clear_status: got %h expected 81", d);
        end
        bus_write(2'd2, 8'h00);
        bus_write(2'd3, 8'h80);
    endtask

    // Load write on a tick edge, then a CTRL en=0 write on the next tick edge.
    task automatic test_load_collision();
        logic [7:0] d;
        logic [7:0] exp_lo [5];
        exp_lo = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h2F};
        bus_write(2'd0, 8'h10);
        bus_write(2'd1, 8'h00);
        bus_write(2'd2, 8'h01);
        idle_cycles(2);
        bus_write(2'd0, 8'h30);
        bus_write(2'd1, 8'h00);
        bus0.cs = 1'b1;
        bus0.we = 1'b0;
        bus0.rs = 2'd0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (bus0.dout !== exp_lo[i]) begin
                bad++;
                $display("[TB] FAIL load_on_tick_step%0d: got %h expected %h", i, bus0.dout, exp_lo[i]);
            end
        end
        bus0.cs = 1'b0;
        idle_cycles(2);
        bus_write(2'd2, 8'h00);
        bus_read(2'd0, d);
        total++;
        if (d !== 8'h2F) begin
            bad++;
            $display("[TB] FAIL ctrl_off_on_tick: got %h expected 2f", d);
        end
    endtask

    task automatic test_read_timing();
        bus_write(2'd2, 8'h06);
        bus0.cs = 1'b1;
        bus0.we = 1'b0;
        bus0.rs = 2'd3;
        @(posedge clk);
        #1;
        bus0.rs = 2'd2;
        #1;
        total++;
        if (bus0.dout !== 8'h00) begin
            bad++;
            $display("[TB] FAIL read_latency_before: got %h expected 00", bus0.dout);
        end
        @(posedge clk);
        #1;
        total++;
        if (bus0.dout !== 8'h06) begin
            bad++;
            $display("[TB] FAIL read_latency_after: got %h expected 06", bus0.dout);
        end
        bus0.cs = 1'b0;
        bus_write(2'd2, 8'h00);
    endtask

    // PRESCALE 1: count 0x0100 decrements every clock once enabled.
    task automatic test_coherent_read();
        logic [7:0] lo;
        logic [7:0] hi;
        bus1.cs  = 1'b1;
        bus1.we  = 1'b1;
        bus1.rs  = 2'd0;
        bus1.din = 8'h00;
        @(posedge clk);
        #1;
        bus1.rs  = 2'd1;
        bus1.din = 8'h01;
        @(posedge clk);
        #1;
        bus1.rs  = 2'd2;
        bus1.din = 8'h01;
        @(posedge clk);
        #1;
        bus1.we = 1'b0;
        bus1.rs = 2'd0;
        @(posedge clk);
        #1;
        lo      = bus1.dout;
        bus1.rs = 2'd1;
        @(posedge clk);
        #1;
        hi      = bus1.dout;
        bus1.cs = 1'b0;
        total++;
        if (lo !== 8'h00) begin
            bad++;
            $display("[TB] FAIL coherent_lo: got %h expected 00", lo);
        end
        total++;
        if (hi !== 8'h01) begin
            bad++;
            $display("[TB] FAIL coherent_hi: got %h expected 01", hi);
        end
    endtask

    initial begin
        reset    = 1'b1;
        bus0.cs  = 1'b0;
        bus0.we  = 1'b0;
        bus0.rs  = 2'd0;
        bus0.din = 8'h00;
        bus1.cs  = 1'b0;
        bus1.we  = 1'b0;
        bus1.rs  = 2'd0;
        bus1.din = 8'h00;
        idle_cycles(2);
        reset = 1'b0;
        #1;

        test_reset();
        test_one_shot();
        test_chip_select();
        test_auto_reload();
        test_load_collision();
        test_read_timing();
        test_coherent_read();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_timer.md
Name: bus_timer

Overview:
- Memory-mapped 16-bit interval timer that acts as a responder on the 6502 CPU bus, selected by a page decode alongside RAM, GPIO and the ACIA.
- A programmable prescaler divides clk into ticks, and a down-counter decrements on each tick.
- On underflow the timer sets a zero flag and can raise irq. It supports one-shot and auto-reload modes.
- Read data is registered (1-cycle latency), matching the SoC's registered data-mux timing.

Parameters:
- PRESCALE, 16, number of clk cycles per counter tick (must be >= 1).

Ports:
- clk, input, 1, system/CPU clock.
- reset, input, 1, synchronous, active-high reset.
- cs, input, 1, chip select from the page decode.
- we, input, 1, CPU write enable (1 = write).
- rs, input, 2, register select (CPU_AB[1:0]).
- din, input, 8, CPU write data.
- dout, output, 8, registered read data.
- irq, output, 1, interrupt request, active-high = zf & ie.

Behaviour:
- Reset clears all of the following: latch=0, count=0, hi_snap=0, en=0, cont=0, ie=0, zf=0, prescaler=0, dout=0, irq=0.
- Register map, writes (cs & we):
  - rs=0: latch[7:0] <= din.
  - rs=1: latch[15:8] <= din; count <= {din, latch[7:0]}; prescaler <= 0. zf is unaffected.
  - rs=2: CTRL, where en=din[0], cont=din[1], ie=din[2].
  - rs=3: if din[7]=1, clear zf (write-1-to-clear). Other bits are ignored.
- Register map, reads: dout is updated every clk edge from rs, regardless of cs, and is valid the cycle after the address.
  - rs=0: count[7:0]. If cs & !we, also hi_snap <= count[15:8] on the same edge.
  - rs=1: hi_snap. Reading lo then hi gives a coherent 16-bit value.
  - rs=2: {5'b0, ie, cont, en}.
  - rs=3: {zf, 6'b0, en}.
- Prescaler:
  - While en=0, the prescaler is held at 0.
  - While en=1, it counts 0..PRESCALE-1 and wraps.
  - tick = en & (prescaler == PRESCALE-1).
- Counter on tick:
  - count != 0: count <= count-1.
  - count == 0: zf <= 1. If cont=1, count <= latch. If cont=0, en <= 0 (one-shot stop) and count stays 0.
- Resulting timing:
  - Period in auto-reload mode = (latch+1)*PRESCALE clk cycles.
  - latch=0 with cont=1 gives zf on every tick.
- Priority and simultaneous events:
  - A rs=1 load write in the same cycle as a tick: the load wins, the tick is discarded, and the prescaler restarts.
  - A zf-clear write in the same cycle as a zf-setting tick: the set wins, and zf remains 1.
  - A CTRL write with en=0 in the same cycle as a tick: the tick is discarded.
  - A CTRL write with en=1 in the same cycle as a one-shot auto-clear of en: the write wins.
  - Writes to latch[7:0] do not affect count until the rs=1 write or the next auto-reload.
- irq:
  - Combinational AND of registered zf and ie.
  - Stays asserted until software clears zf or clears ie. It is level, not pulse.
- Reset mid-count: the next cycle shows all-zero state, irq=0, and the counter stopped.
- No access completes without cs. Writes with cs=0 are ignored. Read side-effects (hi_snap) require cs=1.

Test Plan (PRESCALE=4 unless noted):
- Reset: assert reset 2 cycles with the timer running → the cycle after, dout=0, irq=0; a read of rs=2 returns 0x00 and a read of rs=3 returns 0x00.
- One-shot:
  - Stimulus: write rs0=0x03, rs1=0x00, then CTRL=0x05 (en, ie).
  - Response: zf and irq assert exactly 16 clk after the CTRL write edge; en auto-clears; rs=3 reads 0x80; count holds 0.
- Auto-reload:
  - Stimulus: latch=0x0002, CTRL=0x07.
  - Response: zf sets every 12 clk. Write rs3=0x80 → irq drops the next cycle and reasserts 12 clk after the previous set.
- Coherent read:
  - Stimulus: count=0x0100 running with PRESCALE=1. Read rs0, then rs1 after the lo byte has wrapped to 0xFF.
  - Response: lo=0x00, hi=0x01 (the snapshot), not 0x00.
- Collisions:
  - Write rs3=0x80 on the same edge zf is set → zf=1.
  - Write rs1 on a tick edge → count equals the new load value, and the next decrement comes PRESCALE clk later.
- Chip select and read timing:
  - Writes with cs=0 to every rs → all registers unchanged.
  - Read of rs2 after CTRL=0x06 → dout=0x06 exactly one cycle after rs is presented.
